boss_ctrl: RTL and testbench

Generates the boss sprite's position and animation frame for stage 3. It drives `boss_x`, `boss_y` and `boss_state`, which feed the boss draw logic, the sprite-sheet lookup (frame offset 10·`boss_state`) and the collision logic. Motion and animation advance on a one-cycle per-frame tick. The block also tracks hit points and the hurt and death sequence.

---
 rtl/boss_ctrl_if.sv | 23 ++
 rtl/boss_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_boss_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boss_ctrl_if.sv
// Bus between the stage-3 game logic and the boss controller: game-side
// stimulus in, boss sprite position/animation/status out.
interface boss_ctrl_if;
  logic [3:0] state;
  logic       frame_tick;
  logic       hit;
  logic [8:0] boss_x;
  logic [8:0] boss_y;
  logic [3:0] boss_state;
  logic [3:0] boss_hp;
  logic       boss_active;
  logic       boss_dead;

  modport master (
    output state, frame_tick, hit,
    input  boss_x, boss_y, boss_state, boss_hp, boss_active, boss_dead
  );

  modport slave (
    input  state, frame_tick, hit,
    output boss_x, boss_y, boss_state, boss_hp, boss_active, boss_dead
  );
endinterface

// File: rtl/boss_ctrl.sv
// Stage-3 boss controller: entry descent, left/right patrol with walk
// animation, hit points, hurt invulnerability window and death.
module boss_ctrl #(
  parameter logic [3:0] STAGE3      = 4'd6,
  parameter logic [8:0] X_MIN       = 9'd0,
  parameter logic [8:0] X_MAX       = 9'd310,
  parameter logic [8:0] X_START     = 9'd155,
  parameter logic [8:0] Y_TARGET    = 9'd40,
  parameter logic [8:0] MOVE_STEP   = 9'd1,
  parameter logic [3:0] FRAME_DIV   = 4'd8,
  parameter logic [3:0] HP_INIT     = 4'd8,
  parameter logic [4:0] HURT_FRAMES = 5'd16
) (
  input  logic       clk,
  input  logic       rst,
  boss_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTER  = 3'd1,
    ST_PATROL = 3'd2,
    ST_HURT   = 3'd3,
    ST_DEAD   = 3'd4
  } fsm_e;

  localparam logic [3:0] FRAME_WALK0 = 4'd0;
  localparam logic [3:0] FRAME_HURT  = 4'd4;
  localparam logic [3:0] FRAME_DEAD  = 4'd5;

  fsm_e       fsm_r, fsm_s;
  logic       dir_left_r, dir_left_s;
  logic [3:0] anim_div_r, anim_div_s;
  logic [4:0] hurt_cnt_r, hurt_cnt_s;
  logic [8:0] x_r, x_s;
  logic [8:0] y_r, y_s;
  logic [3:0] frame_r, frame_s;
  logic [3:0] hp_r, hp_s;
  logic       active_r, active_s;
  logic       dead_r, dead_s;

  logic       in_stage_s;
  logic [9:0] y_sum_s;
  logic [9:0] x_sum_s;
  logic [9:0] x_floor_s;
  logic       anim_wrap_s;
  logic [3:0] anim_next_s;
  logic [3:0] frame_walk_s;

  // Walk frames cycle through 0..3 only.
  function automatic logic [3:0] next_walk(input logic [3:0] f);
    next_walk = {2'b00, f[1:0] + 2'd1};
  endfunction

  // Shared arithmetic, one bit wider than the position so bounds never wrap
  always_comb begin
    in_stage_s   = (bus.state == STAGE3);
    y_sum_s      = {1'b0, y_r} + {1'b0, MOVE_STEP};
    x_sum_s      = {1'b0, x_r} + {1'b0, MOVE_STEP};
    x_floor_s    = {1'b0, X_MIN} + {1'b0, MOVE_STEP};
    anim_wrap_s  = (({1'b0, anim_div_r} + 5'd1) >= {1'b0, FRAME_DIV});
    anim_next_s  = anim_wrap_s ? 4'd0 : (anim_div_r + 4'd1);
    frame_walk_s = anim_wrap_s ? next_walk(frame_r) : frame_r;
  end

  // Next-state and next-output logic
  always_comb begin
    fsm_s      = fsm_r;
    dir_left_s = dir_left_r;
    anim_div_s = anim_div_r;
    hurt_cnt_s = hurt_cnt_r;
    x_s        = x_r;
    y_s        = y_r;
    frame_s    = frame_r;
    hp_s       = hp_r;
    active_s   = active_r;
    dead_s     = dead_r;

    if ((fsm_r != ST_IDLE) && !in_stage_s) begin
      // Leaving the stage overrides everything else.
      fsm_s      = ST_IDLE;
      dir_left_s = 1'b0;
      anim_div_s = 4'd0;
      hurt_cnt_s = 5'd0;
      x_s        = X_START;
      y_s        = 9'd0;
      frame_s    = FRAME_WALK0;
      hp_s       = HP_INIT;
      active_s   = 1'b0;
      dead_s     = 1'b0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (in_stage_s) begin
            fsm_s    = ST_ENTER;
            active_s = 1'b1;
          end else begin
            fsm_s = ST_IDLE;
          end
        end

        ST_ENTER: begin
          if (bus.frame_tick) begin
            anim_div_s = anim_next_s;
            frame_s    = frame_walk_s;
            if (y_sum_s >= {1'b0, Y_TARGET}) begin
              // Patrol starts from a clean walk cycle heading right.
              y_s        = Y_TARGET;
              fsm_s      = ST_PATROL;
              dir_left_s = 1'b0;
              anim_div_s = 4'd0;
              frame_s    = FRAME_WALK0;
            end else begin
              y_s = y_sum_s[8:0];
            end
          end else begin
            fsm_s = ST_ENTER;
          end
        end

        ST_PATROL: begin
          if (bus.hit) begin
            if (hp_r <= 4'd1) begin
              hp_s     = 4'd0;
              fsm_s    = ST_DEAD;
              frame_s  = FRAME_DEAD;
              active_s = 1'b0;
              dead_s   = 1'b1;
            end else begin
              hp_s       = hp_r - 4'd1;
              fsm_s      = ST_HURT;
              hurt_cnt_s = HURT_FRAMES;
              frame_s    = FRAME_HURT;
            end
          end else if (bus.frame_tick) begin
            anim_div_s = anim_next_s;
            frame_s    = frame_walk_s;
            if (dir_left_r) begin
              if ({1'b0, x_r} <= x_floor_s) begin
                x_s        = X_MIN;
                dir_left_s = 1'b0;
              end else begin
                x_s = x_r - MOVE_STEP;
              end
            end else begin
              if (x_sum_s >= {1'b0, X_MAX}) begin
                x_s        = X_MAX;
                dir_left_s = 1'b1;
              end else begin
                x_s = x_sum_s[8:0];
              end
            end
          end else begin
            fsm_s = ST_PATROL;
          end
        end

        ST_HURT: begin
          if (bus.frame_tick) begin
            if (hurt_cnt_r <= 5'd1) begin
              hurt_cnt_s = 5'd0;
              fsm_s      = ST_PATROL;
              frame_s    = FRAME_WALK0;
              anim_div_s = 4'd0;
            end else begin
              hurt_cnt_s = hurt_cnt_r - 5'd1;
            end
          end else begin
            fsm_s = ST_HURT;
          end
        end

        ST_DEAD: begin
          fsm_s = ST_DEAD;
        end

        default: begin
          fsm_s      = ST_IDLE;
          dir_left_s = 1'b0;
          anim_div_s = 4'd0;
          hurt_cnt_s = 5'd0;
          x_s        = X_START;
          y_s        = 9'd0;
          frame_s    = FRAME_WALK0;
          hp_s       = HP_INIT;
          active_s   = 1'b0;
          dead_s     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r      <= ST_IDLE;
      dir_left_r <= 1'b0;
      anim_div_r <= 4'd0;
      hurt_cnt_r <= 5'd0;
      x_r        <= X_START;
      y_r        <= 9'd0;
      frame_r    <= FRAME_WALK0;
      hp_r       <= HP_INIT;
      active_r   <= 1'b0;
      dead_r     <= 1'b0;
    end else begin
      fsm_r      <= fsm_s;
      dir_left_r <= dir_left_s;
      anim_div_r <= anim_div_s;
      hurt_cnt_r <= hurt_cnt_s;
      x_r        <= x_s;
      y_r        <= y_s;
      frame_r    <= frame_s;
      hp_r       <= hp_s;
      active_r   <= active_s;
      dead_r     <= dead_s;
    end
  end

  assign bus.boss_x      = x_r;
  assign bus.boss_y      = y_r;
  assign bus.boss_state  = frame_r;
  assign bus.boss_hp     = hp_r;
  assign bus.boss_active = active_r;
  assign bus.boss_dead   = dead_r;

endmodule

// File: tb/tb_boss_ctrl.sv
// Self-checking bench for boss_ctrl: directed scenario with randomized gaps
// and spurious hits, compared every cycle against a behavioural model.
module tb_boss_ctrl;

  localparam int X_START     = 155;
  localparam int X_SPAN      = 310;
  localparam int Y_TARGET    = 40;
  localparam int FRAME_DIV   = 8;
  localparam int HP_INIT     = 8;
  localparam int HURT_FRAMES = 16;

  localparam int M_OFF    = 0;
  localparam int M_ENTER  = 1;
  localparam int M_PATROL = 2;
  localparam int M_HURT   = 3;
  localparam int M_DEAD   = 4;

  logic clk = 1'b0;
  logic rst;

  boss_ctrl_if bif ();

  boss_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode plus event counters; position derived arithmetically.
  int m_mode;
  int enter_ticks;
  int patrol_n;
  int walk;
  int hits;
  int hurt_left;

  task automatic model_reset();
    m_mode      = M_OFF;
    enter_ticks = 0;
    patrol_n    = 0;
    walk        = 0;
    hits        = 0;
    hurt_left   = 0;
  endtask

  // Patrol is a triangle wave over [0, X_SPAN] starting at X_START going right.
  function automatic int exp_x(input int n);
    int u;
    u = (X_START + n) % (2 * X_SPAN);
    return (u <= X_SPAN) ? u : (2 * X_SPAN - u);
  endfunction

  task automatic model_step(input logic r, input logic [3:0] st, input logic tk, input logic ht);
    if (r) begin
      model_reset();
    end else if (m_mode != M_OFF && st != 4'd6) begin
      model_reset();
    end else begin
      case (m_mode)
        M_OFF: if (st == 4'd6) m_mode = M_ENTER;
        M_ENTER: if (tk) begin
          enter_ticks++;
          walk++;
          if (enter_ticks >= Y_TARGET) begin
            m_mode = M_PATROL;
            walk   = 0;
          end
        end
        M_PATROL: begin
          if (ht) begin
            hits++;
            if (hits >= HP_INIT) m_mode = M_DEAD;
            else begin
              m_mode    = M_HURT;
              hurt_left = HURT_FRAMES;
            end
          end else if (tk) begin
            patrol_n++;
            walk++;
          end
        end
        M_HURT: if (tk) begin
          hurt_left--;
          if (hurt_left == 0) begin
            m_mode = M_PATROL;
            walk   = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    int es;
    int ey;
    ey = (enter_ticks < Y_TARGET) ? enter_ticks : Y_TARGET;
    es = (m_mode == M_DEAD) ? 5 : (m_mode == M_HURT) ? 4 : ((walk / FRAME_DIV) % 4);
    check("boss_x",      {1'b0, bif.boss_x},      10'(exp_x(patrol_n)));
    check("boss_y",      {1'b0, bif.boss_y},      10'(ey));
    check("boss_state",  {6'd0, bif.boss_state},  10'(es));
    check("boss_hp",     {6'd0, bif.boss_hp},     10'(HP_INIT - hits));
    check("boss_active", {9'd0, bif.boss_active},
          10'((m_mode == M_ENTER || m_mode == M_PATROL || m_mode == M_HURT) ? 1 : 0));
    check("boss_dead",   {9'd0, bif.boss_dead},   10'((m_mode == M_DEAD) ? 1 : 0));
  endtask

  // One clock: drive, let the DUT sample, advance the model, compare.
  task automatic cyc(input logic tk, input logic ht);
    bif.frame_tick = tk;
    bif.hit        = ht;
    @(posedge clk);
    model_step(rst, bif.state, tk, ht);
    #1;
    bif.frame_tick = 1'b0;
    bif.hit        = 1'b0;
    check_all();
  endtask

  // n frame ticks, each preceded by 0..2 quiet cycles; optional stray hits.
  task automatic ticks(input int n, input bit rand_hit);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++)
        cyc(1'b0, rand_hit && ($urandom_range(0, 1) == 1));
      cyc(1'b1, rand_hit && ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    rst            = 1'b1;
    bif.state      = 4'd0;
    bif.frame_tick = 1'b0;
    bif.hit        = 1'b0;
    model_reset();

    // Reset and idle
    for (int i = 0; i < 100; i++) cyc(1'b1, $urandom_range(0, 1) == 1);
    check("rst_x",      {1'b0, bif.boss_x},      10'd155);
    check("rst_y",      {1'b0, bif.boss_y},      10'd0);
    check("rst_state",  {6'd0, bif.boss_state},  10'd0);
    check("rst_hp",     {6'd0, bif.boss_hp},     10'd8);
    check("rst_active", {9'd0, bif.boss_active}, 10'd0);
    rst = 1'b0;

    // Entry
    bif.state = 4'd6;
    cyc(1'b0, 1'b0);
    check("enter_active", {9'd0, bif.boss_active}, 10'd1);
    check("enter_y0",     {1'b0, bif.boss_y},      10'd0);
    ticks(40, 1'b1);
    check("entry_y", {1'b0, bif.boss_y}, 10'd40);
    ticks(8, 1'b0);
    check("walk_state1", {6'd0, bif.boss_state}, 10'd1);
    check("walk_x163",   {1'b0, bif.boss_x},     10'd163);

    // Patrol bounce
    ticks(147, 1'b0);
    check("bounce_max",  {1'b0, bif.boss_x}, 10'd310);
    ticks(1, 1'b0);
    check("bounce_309",  {1'b0, bif.boss_x}, 10'd309);
    ticks(309, 1'b0);
    check("bounce_min",  {1'b0, bif.boss_x}, 10'd0);
    ticks(1, 1'b0);
    check("bounce_1",    {1'b0, bif.boss_x}, 10'd1);

    // Hurt
    cyc(1'b0, 1'b1);
    check("hurt_hp",    {6'd0, bif.boss_hp},    10'd7);
    check("hurt_state", {6'd0, bif.boss_state}, 10'd4);
    cyc(1'b0, 1'b1);
    check("hurt_rehit", {6'd0, bif.boss_hp},    10'd7);
    ticks(15, 1'b1);
    check("hurt_frozen", {1'b0, bif.boss_x},     10'd1);
    check("hurt_still",  {6'd0, bif.boss_state}, 10'd4);
    ticks(1, 1'b0);
    check("hurt_done",   {6'd0, bif.boss_state}, 10'd0);
    ticks(1, 1'b0);
    check("hurt_moves",  {1'b0, bif.boss_x},     10'd2);

    // Simultaneous hit and tick
    cyc(1'b1, 1'b1);
    check("simul_hp", {6'd0, bif.boss_hp}, 10'd6);
    check("simul_x",  {1'b0, bif.boss_x},  10'd2);
    ticks(16, 1'b0);

    // Death
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1);
      ticks(16, 1'b0);
    end
    check("dead_flag",   {9'd0, bif.boss_dead},   10'd1);
    check("dead_state",  {6'd0, bif.boss_state},  10'd5);
    check("dead_active", {9'd0, bif.boss_active}, 10'd0);
    check("dead_hp",     {6'd0, bif.boss_hp},     10'd0);
    ticks(3, 1'b1);

    // Stage exit and re-entry
    bif.state = 4'd0;
    cyc(1'b0, 1'b0);
    check("exit_x",    {1'b0, bif.boss_x},     10'd155);
    check("exit_y",    {1'b0, bif.boss_y},     10'd0);
    check("exit_hp",   {6'd0, bif.boss_hp},    10'd8);
    check("exit_dead", {9'd0, bif.boss_dead},  10'd0);
    bif.state = 4'd6;
    cyc(1'b0, 1'b0);
    ticks(40, 1'b1);
    check("reentry_y", {1'b0, bif.boss_y}, 10'd40);

    // Reset in the middle of HURT
    ticks(3, 1'b0);
    cyc(1'b0, 1'b1);
    ticks(5, 1'b0);
    check("midhurt_state", {6'd0, bif.boss_state}, 10'd4);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    check("rst_hurt_state", {6'd0, bif.boss_state}, 10'd0);
    check("rst_hurt_hp",    {6'd0, bif.boss_hp},    10'd8);
    check("rst_hurt_y",     {1'b0, bif.boss_y},     10'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    check("rst_reenter", {9'd0, bif.boss_active}, 10'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
